// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- interrupt controller between peripheral interrupt sources and
// the core's irq/eoi pins.
//
// Raw source events are latched into PENDING. Each source is configured as
// rising-edge or level through EDGE. Requests are PENDING & ENABLE. The lowest
// requesting index is presented to the core as a one-hot irq vector and held
// until the core pulses eoi. There is no preemption. After eoi, irq stays low
// for one GAP cycle. The controller then re-arbitrates from IDLE.
//
// Register map (byte addresses, word aligned):
//   0x00 PENDING  R / write-1-to-clear
//   0x04 ENABLE   RW
//   0x08 EDGE     RW  (1 = rising edge, 0 = level)
//   0x0C ACTIVE   R   (source currently being served, one-hot)
//   0x10 SET      W   (write 1 sets pending bits; reads as 0)
// Unmapped reads return 0. Unmapped writes are ignored.
//
// Optional build macro:
//   IRQ_SYNC_EN  when defined, src passes through a 2-flop synchronizer before
//                event detection. This adds 2 cycles of src-to-irq latency.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   src         raw interrupt lines [NUM_SRC-1:0]
//   irq         one-hot interrupt request to the core (registered)
//   eoi         end-of-interrupt pulse from the core
//   reg_addr    register byte address
//   reg_wdata   register write data
//   reg_we      register write strobe
//   reg_re      register read strobe
//   reg_rdata   register read data, valid one cycle after reg_re
//   reg_rvalid  one-cycle read-data-valid pulse
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_SRC = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  output logic [31:0]        irq,
  input  logic               eoi,
  input  logic [ADDR_W-1:0]  reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_we,
  input  logic               reg_re,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid
);

  // Bits at and above NUM_SRC never hold state.
  localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFF >> (32 - NUM_SRC);

  localparam logic [ADDR_W-1:0] ADDR_PENDING = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] ADDR_ENABLE  = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] ADDR_SET     = ADDR_W'(32'h10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Isolates the lowest set bit (highest priority). The result is one-hot,
  // or zero when v is zero.
  function automatic logic [31:0] lowest_onehot(input logic [31:0] v);
    lowest_onehot = v & (~v + 32'd1);
  endfunction

  // Register read multiplexer. SET is write-only and reads as zero.
  function automatic logic [31:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [31:0]       pending,
    input logic [31:0]       enable,
    input logic [31:0]       edge_mode,
    input logic [31:0]       active
  );
    case (addr)
      ADDR_PENDING: read_mux = pending;
      ADDR_ENABLE:  read_mux = enable;
      ADDR_EDGE:    read_mux = edge_mode;
      ADDR_ACTIVE:  read_mux = active;
      ADDR_SET:     read_mux = 32'h0000_0000;
      default:      read_mux = 32'h0000_0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and internal signals
  // ---------------------------------------------------------------------------
  logic [31:0] pending_r;
  logic [31:0] enable_r;
  logic [31:0] edge_mode_r;
  logic [31:0] active_r;
  logic [31:0] irq_r;
  logic [31:0] src_q_r;
  logic [31:0] rdata_r;
  logic        rvalid_r;
  state_t      state_r;

  logic [31:0] src_ext_s;
  logic [31:0] src_eff_s;
  logic [31:0] evt_s;
  logic [31:0] set_bits_s;
  logic [31:0] clr_bits_s;
  logic [31:0] pending_nxt_s;
  logic [31:0] masked_s;
  logic [31:0] grant_s;
  logic [31:0] active_nxt_s;
  logic [31:0] irq_nxt_s;
  logic        eoi_clr_s;
  state_t      state_nxt_s;

  logic        wr_pending_s;
  logic        wr_enable_s;
  logic        wr_edge_s;
  logic        wr_set_s;

  assign src_ext_s = 32'(src);

`ifdef IRQ_SYNC_EN
  logic [31:0] sync1_r;
  logic [31:0] sync2_r;

  // Two-flop synchronizer for sources that are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 32'h0000_0000;
      sync2_r <= 32'h0000_0000;
    end else begin
      sync1_r <= src_ext_s;
      sync2_r <= sync1_r;
    end
  end

  assign src_eff_s = sync2_r;
`else
  assign src_eff_s = src_ext_s;
`endif

  // ---------------------------------------------------------------------------
  // Register-port write decode
  // ---------------------------------------------------------------------------
  assign wr_pending_s = reg_we && (reg_addr == ADDR_PENDING);
  assign wr_enable_s  = reg_we && (reg_addr == ADDR_ENABLE);
  assign wr_edge_s    = reg_we && (reg_addr == ADDR_EDGE);
  assign wr_set_s     = reg_we && (reg_addr == ADDR_SET);

  // ---------------------------------------------------------------------------
  // Event detection and pending update
  // ---------------------------------------------------------------------------
  // Edge sources fire on a 0->1 transition. Level sources fire every cycle
  // the line is high.
  assign evt_s = ((edge_mode_r & src_eff_s & ~src_q_r) |
                  (~edge_mode_r & src_eff_s)) & SRC_MASK;

  // Set sources win over clear sources in the same cycle. This lets a level
  // line that is still high at eoi re-pend immediately.
  assign set_bits_s    = evt_s | (wr_set_s ? reg_wdata : 32'h0000_0000);
  assign clr_bits_s    = (wr_pending_s ? reg_wdata : 32'h0000_0000) |
                         (eoi_clr_s ? active_r : 32'h0000_0000);
  assign pending_nxt_s = (set_bits_s | (pending_r & ~clr_bits_s)) & SRC_MASK;

  assign masked_s = pending_r & enable_r;
  assign grant_s  = lowest_onehot(masked_s);

  // Previous-cycle copy of the (optionally synchronized) source lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q_r <= 32'h0000_0000;
    end else begin
      src_q_r <= src_eff_s;
    end
  end

  // PENDING, ENABLE and EDGE configuration/status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r   <= 32'h0000_0000;
      enable_r    <= 32'h0000_0000;
      edge_mode_r <= 32'h0000_0000;
    end else begin
      pending_r <= pending_nxt_s;
      if (wr_enable_s) begin
        enable_r <= reg_wdata & SRC_MASK;
      end else begin
        enable_r <= enable_r;
      end
      if (wr_edge_s) begin
        edge_mode_r <= reg_wdata & SRC_MASK;
      end else begin
        edge_mode_r <= edge_mode_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Service FSM
  // ---------------------------------------------------------------------------
  // State, ACTIVE and irq registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      active_r <= 32'h0000_0000;
      irq_r    <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      active_r <= active_nxt_s;
      irq_r    <= irq_nxt_s;
    end
  end

  // Next-state logic. SERVE ignores new requests, including higher-priority
  // ones, and PENDING/ENABLE changes of the served source. Only eoi ends
  // service.
  always_comb begin
    state_nxt_s  = state_r;
    active_nxt_s = active_r;
    irq_nxt_s    = irq_r;
    eoi_clr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (masked_s != 32'h0000_0000) begin
          active_nxt_s = grant_s;
          irq_nxt_s    = grant_s;
          state_nxt_s  = ST_SERVE;
        end else begin
          active_nxt_s = 32'h0000_0000;
          irq_nxt_s    = 32'h0000_0000;
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (eoi) begin
          eoi_clr_s    = 1'b1;
          active_nxt_s = 32'h0000_0000;
          irq_nxt_s    = 32'h0000_0000;
          state_nxt_s  = ST_GAP;
        end else begin
          active_nxt_s = active_r;
          irq_nxt_s    = active_r;
          state_nxt_s  = ST_SERVE;
        end
      end
      ST_GAP: begin
        active_nxt_s = 32'h0000_0000;
        irq_nxt_s    = 32'h0000_0000;
        state_nxt_s  = ST_IDLE;
      end
      default: begin
        // Unreachable encoding: fall back to a quiet IDLE.
        active_nxt_s = 32'h0000_0000;
        irq_nxt_s    = 32'h0000_0000;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register-port read path
  // ---------------------------------------------------------------------------
  // Read data is registered from the pre-write register values. A
  // simultaneous write therefore does not affect the returned word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r  <= 32'h0000_0000;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= reg_re;
      if (reg_re) begin
        rdata_r <= read_mux(reg_addr, pending_r, enable_r, edge_mode_r, active_r);
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign irq        = irq_r;
  assign reg_rdata  = rdata_r;
  assign reg_rvalid = rvalid_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl -- scoreboard testbench for irq_ctrl.
// Stimulus pushes expected irq/reg_rvalid values, tagged with the clock edge
// they must hold after, into sig_q. It pushes expected read data into rd_q.
// A monitor samples on the falling edge and pops/compares.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam logic [4:0] A_PENDING = 5'h00;
  localparam logic [4:0] A_ENABLE  = 5'h04;
  localparam logic [4:0] A_EDGE    = 5'h08;
  localparam logic [4:0] A_ACTIVE  = 5'h0C;
  localparam logic [4:0] A_SET     = 5'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src;
  logic [31:0] irq;
  logic        eoi;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  irq_ctrl #(.NUM_SRC(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .irq        (irq),
    .eoi        (eoi),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          sel;    // 0: irq, 1: reg_rvalid
    logic [31:0] val;
    string       name;
  } sig_exp_t;

  typedef struct {
    logic [31:0] val;
    string       name;
  } rd_exp_t;

  sig_exp_t sig_q[$];
  rd_exp_t  rd_q[$];
  int tests = 0;
  int fails = 0;

  // Expect signal value after edge 'at' (kept sorted by edge).
  task automatic expect_sig(input int at, input bit sel, input logic [31:0] val,
                            input string name);
    sig_exp_t e;
    int idx;
    e.at = at; e.sel = sel; e.val = val; e.name = name;
    idx = sig_q.size();
    for (int i = 0; i < sig_q.size(); i++) begin
      if (sig_q[i].at > at) begin
        idx = i;
        break;
      end
    end
    sig_q.insert(idx, e);
  endtask

  task automatic push_rd(input logic [31:0] val, input string name);
    rd_exp_t r;
    r.val = val; r.name = name;
    rd_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
    step();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] val, input string name);
    reg_re = 1'b1; reg_addr = addr;
    push_rd(val, name);
    step();
    reg_re = 1'b0;
  endtask

  // Monitor: compares scheduled signal expectations and read returns.
  initial begin
    sig_exp_t    e;
    rd_exp_t     r;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sig_q.size() > 0 && sig_q[0].at <= cyc) begin
        e = sig_q.pop_front();
        act = e.sel ? {31'b0, reg_rvalid} : irq;
        tests++;
        if (e.at != cyc) begin
          fails++;
          $display("FAIL %s: check for edge %0d missed (now edge %0d)", e.name, e.at, cyc);
        end else if (act !== e.val) begin
          fails++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
        end
      end
      if (reg_rvalid === 1'b1) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rvalid: got rvalid=1 data 0x%08h, expected no read", reg_rdata);
        end else begin
          r = rd_q.pop_front();
          if (reg_rdata !== r.val) begin
            fails++;
            $display("FAIL %s: read 0x%08h, expected 0x%08h", r.name, reg_rdata, r.val);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; src = 32'h1; eoi = 1'b0;
    reg_we = 1'b0; reg_re = 1'b0; reg_addr = 5'h00; reg_wdata = 32'h0;

    // Reset state with a level-high source held during reset.
    step(); step();
    expect_sig(cyc, 1'b0, 32'h0, "rst_irq");
    expect_sig(cyc, 1'b1, 32'h0, "rst_rvalid");
    step();
    src = 32'h0;
    step();
    reset = 1'b0;
    step();
    rd(A_PENDING, 32'h0, "rst_pending");
    rd(A_ENABLE,  32'h0, "rst_enable");
    rd(A_ACTIVE,  32'h0, "rst_active");

    // Edge source 2: pending after edge k, irq after k+1, eoi gap.
    wr(A_ENABLE, 32'h5);
    wr(A_EDGE,   32'h5);
    src = 32'h4;
    step();
    src = 32'h0;
    expect_sig(cyc,     1'b0, 32'h0, "t2_irq_not_yet");
    expect_sig(cyc + 1, 1'b0, 32'h4, "t2_irq");
    rd(A_PENDING, 32'h4, "t2_pending");
    step();
    expect_sig(cyc, 1'b0, 32'h4, "t2_irq_hold");
    eoi = 1'b1;
    expect_sig(cyc + 1, 1'b0, 32'h0, "t2_gap");
    expect_sig(cyc + 2, 1'b0, 32'h0, "t2_idle");
    step();
    eoi = 1'b0;
    step(); step();
    rd(A_PENDING, 32'h0, "t2_pending_clr");

    // Sources 0 and 2 together: priority to 0, then 2 after the gap.
    src = 32'h5;
    step();
    src = 32'h0;
    expect_sig(cyc + 1, 1'b0, 32'h1, "t3_first");
    step(); step();
    rd(A_ACTIVE, 32'h1, "t3_active");
    eoi = 1'b1;
    expect_sig(cyc + 1, 1'b0, 32'h0, "t3_gap");
    expect_sig(cyc + 2, 1'b0, 32'h0, "t3_gap_idle");
    expect_sig(cyc + 3, 1'b0, 32'h4, "t3_second");
    step();
    eoi = 1'b0;
    step(); step();
    eoi = 1'b1;
    expect_sig(cyc + 1, 1'b0, 32'h0, "t3_second_eoi");
    expect_sig(cyc + 3, 1'b0, 32'h0, "t3_none");
    step();
    eoi = 1'b0;
    step(); step(); step();
    rd(A_PENDING, 32'h0, "t3_pending");

    // Level source 3 held high across eoi re-pends.
    wr(A_ENABLE, 32'h8);
    src = 32'h8;
    step();
    expect_sig(cyc + 1, 1'b0, 32'h8, "t4_first");
    step(); step();
    eoi = 1'b1;
    expect_sig(cyc + 1, 1'b0, 32'h0, "t4_gap");
    expect_sig(cyc + 3, 1'b0, 32'h8, "t4_repend");
    step();
    eoi = 1'b0;
    step(); step();
    src = 32'h0;
    step();
    expect_sig(cyc, 1'b0, 32'h8, "t4_hold_src_low");
    eoi = 1'b1;
    expect_sig(cyc + 1, 1'b0, 32'h0, "t4_eoi_low");
    expect_sig(cyc + 3, 1'b0, 32'h0, "t4_stays_low");
    step();
    eoi = 1'b0;
    step(); step(); step();
    rd(A_PENDING, 32'h0, "t4_pending");

    // Clearing PENDING/ENABLE of the served source does not drop irq.
    wr(A_EDGE,   32'h2);
    wr(A_ENABLE, 32'h2);
    src = 32'h2;
    step();
    src = 32'h0;
    expect_sig(cyc + 1, 1'b0, 32'h2, "t5_irq");
    step(); step();
    wr(A_PENDING, 32'h2);
    wr(A_ENABLE,  32'h0);
    expect_sig(cyc, 1'b0, 32'h2, "t5_hold_after_clear");
    step();
    expect_sig(cyc, 1'b0, 32'h2, "t5_hold2");
    rd(A_PENDING, 32'h0, "t5_pending_w1c");
    rd(A_ACTIVE,  32'h2, "t5_active");
    eoi = 1'b1;
    expect_sig(cyc + 1, 1'b0, 32'h0, "t5_eoi");
    expect_sig(cyc + 3, 1'b0, 32'h0, "t5_idle");
    step();
    eoi = 1'b0;
    step(); step(); step();
    // eoi in IDLE must not touch a pending (disabled) source.
    wr(A_SET, 32'h1);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    step();
    expect_sig(cyc, 1'b0, 32'h0, "t5_idle_eoi_irq");
    rd(A_PENDING, 32'h1, "t5_idle_eoi_pending");
    rd(A_ACTIVE,  32'h0, "t5_idle_eoi_active");
    wr(A_PENDING, 32'h1);
    rd(A_PENDING, 32'h0, "t5_w1c");

    // SET, set-wins-over-W1C, unmapped access, read/write collision.
    wr(A_EDGE, 32'h10);
    wr(A_SET,  32'h10);
    rd(A_PENDING, 32'h10, "t6_set");
    reg_we = 1'b1; reg_addr = A_PENDING; reg_wdata = 32'h10; src = 32'h10;
    step();
    reg_we = 1'b0; src = 32'h0;
    rd(A_PENDING, 32'h10, "t6_set_wins");
    rd(A_SET,     32'h0,  "t6_set_reads0");
    rd(5'h14,     32'h0,  "t6_unmapped_rd");
    wr(5'h18, 32'hFFFF_FFFF);
    rd(A_ENABLE,  32'h0,  "t6_unmapped_wr");
    reg_we = 1'b1; reg_addr = A_ENABLE; reg_wdata = 32'h10;
    step();
    reg_we = 1'b0;
    expect_sig(cyc,     1'b0, 32'h0,  "t6_irq_pre");
    expect_sig(cyc + 1, 1'b0, 32'h10, "t6_irq");
    step(); step();
    reg_re = 1'b1; reg_addr = A_ACTIVE;
    push_rd(32'h10, "t6_active");
    expect_sig(cyc + 1, 1'b1, 32'h1, "t6_rvalid");
    expect_sig(cyc + 2, 1'b1, 32'h0, "t6_rvalid_pulse");
    step();
    reg_re = 1'b0;
    step();
    reg_re = 1'b1; reg_we = 1'b1; reg_addr = A_ENABLE; reg_wdata = 32'h30;
    push_rd(32'h10, "t6_rw_old");
    step();
    reg_re = 1'b0; reg_we = 1'b0;
    rd(A_ENABLE, 32'h30, "t6_rw_new");

    // Asynchronous reset clears irq before the next clock edge.
    expect_sig(cyc, 1'b0, 32'h10, "t7_pre");
    step();
    reset = 1'b1;
    expect_sig(cyc, 1'b0, 32'h0, "t7_async_irq");
    step();
    reset = 1'b0;
    step();
    rd(A_ENABLE,  32'h0, "t7_enable");
    rd(A_PENDING, 32'h0, "t7_pending");

    step(); step(); step();
    tests++;
    if (sig_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d signal and %0d read expectations left, expected 0 and 0",
               sig_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
